// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input, instruction-memory write port and
// core-control signals of the boot loader, grouped as one bundle.
// The master modport is the loader itself; the slave modport is the
// surrounding system (byte source, instruction memory and core).
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  reload;
    logic                  mem_we;
    logic [3:0]            mem_ctrl;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_di;
    logic                  init_active;
    logic                  core_rst_n;
    logic                  done;
    logic                  err;

    modport master (
        input  in_valid, in_byte, reload,
        output in_ready, mem_we, mem_ctrl, mem_addr, mem_di,
        output init_active, core_rst_n, done, err
    );

    modport slave (
        output in_valid, in_byte, reload,
        input  in_ready, mem_we, mem_ctrl, mem_addr, mem_di,
        input  init_active, core_rst_n, done, err
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory at consecutive word addresses, then
// holds the core in reset for HOLD_CYCLES cycles before letting it run.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN -- when defined, one
// extra byte after the last word must equal the 8-bit sum of all data
// bytes; a mismatch parks the loader in ERROR until rst or reload.
// All outputs come from registers or are decoded from the state register.
module boot_loader #(
    parameter int          WORD_COUNT  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          HOLD_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    boot_loader_if.master bus
);

    // Word counter is wide enough for WORD_COUNT up to 1024.
    localparam int WCW = 11;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_WRITE = 3'd1,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHECK = 3'd2,
`endif
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_byte_cnt;
    logic [WCW-1:0]        r_word_cnt;
    logic [7:0]            r_hold_cnt;
    logic [31:0]           r_word;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  w_last_word;
    logic                  w_hold_done;
    logic [ADDR_WIDTH-1:0] w_word_addr;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]            r_sum;
`endif

    assign w_last_word = (r_word_cnt == WCW'(WORD_COUNT - 1));
    assign w_hold_done = (r_hold_cnt == 8'(HOLD_CYCLES - 1));
    assign w_word_addr = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(r_word_cnt) << 2);

    // Outputs decoded purely from the state register (no input-to-output path).
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign bus.in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign bus.err      = (r_state == S_ERROR);
`else
    assign bus.in_ready = (r_state == S_LOAD);
    assign bus.err      = 1'b0;
`endif
    assign bus.mem_we      = (r_state == S_WRITE);
    assign bus.mem_ctrl    = (r_state == S_WRITE) ? 4'b1111 : 4'b0000;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_di      = r_word;
    // Memory mux goes to the core only once the image is complete.
    assign bus.init_active = !((r_state == S_HOLD) || (r_state == S_RUN));
    assign bus.core_rst_n  = (r_state == S_RUN);
    assign bus.done        = (r_state == S_RUN);

    // State register with synchronous reset back to LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (bus.in_valid && (r_byte_cnt == 2'd3)) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_HOLD;
`endif
                end else begin
                    w_next_state = S_LOAD;
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (bus.in_valid) begin
                    w_next_state = (bus.in_byte == r_sum) ? S_HOLD : S_ERROR;
                end else begin
                    w_next_state = S_CHECK;
                end
            end
`endif
            S_HOLD: begin
                if (w_hold_done) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            S_RUN, S_ERROR: begin
                if (bus.reload) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    // Datapath: byte assembly, word/hold counters, write address and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_hold_cnt <= 8'd0;
            r_word     <= 32'h0000_0000;
            r_mem_addr <= ADDR_WIDTH'(BASE_ADDR);
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        // Lanes are overwritten in order, so the buffer is never cleared.
                        r_word[{r_byte_cnt, 3'b000} +: 8] <= bus.in_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + bus.in_byte;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr <= w_word_addr;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + WCW'(1);
                    r_hold_cnt <= 8'd0;
                end
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                end
                S_RUN, S_ERROR: begin
                    if (bus.reload) begin
                        r_byte_cnt <= 2'd0;
                        r_word_cnt <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_sum      <= 8'd0;
`endif
                    end
                end
                default: begin
                    r_hold_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
